// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT front end and butterfly.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fft_pkg;

  localparam int N        = 8;
  localparam int IN_W     = 16;
  localparam int OUT_W    = 32;
  localparam int FRAC_IN  = 8;
  localparam int FRAC_OUT = 16;
  localparam int SHIFT    = FRAC_OUT - FRAC_IN;

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } cplx32_t;

  // Twiddles W8^k = exp(-j*2*pi*k/8) for the butterfly, Q16.16.
  localparam cplx32_t W0 = '{re: 32'sh0001_0000, im: 32'sh0000_0000};
  localparam cplx32_t W2 = '{re: 32'sh0000_0000, im: 32'shFFFF_0000};
  localparam cplx32_t W4 = '{re: 32'shFFFF_0000, im: 32'sh0000_0000};
  localparam cplx32_t W6 = '{re: 32'sh0000_0000, im: 32'sh0001_0000};

  // Q8.8 -> Q16.16: sign-extend, then move the binary point; exact, no rounding.
  function automatic logic signed [OUT_W-1:0] q88_to_q1616(input logic signed [IN_W-1:0] x);
    logic signed [OUT_W-1:0] ext;
    ext = {{(OUT_W-IN_W){x[IN_W-1]}}, x};
    return ext <<< SHIFT;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// 8-entry complex register bank: one write port, all entries read in parallel.
// Latency: write visible on the read port the cycle after the enabled edge.
// Backpressure: none; the caller decides when to write.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [2:0]          i_waddr,
  input  cplx32_t             i_wdat,
  output cplx32_t [N-1:0]     o_words
);

  cplx32_t [N-1:0] r_mem;

  // Storage is cleared on reset so the frame outputs read as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_words = r_mem;

endmodule

// File: rtl/fft_input_collector.sv
// Serial-to-parallel collector: Q8.8 samples in, 8-sample Q16.16 frames out, double-buffered.
// Latency: frame_valid rises the cycle after the 8th sample of a frame is accepted.
// Backpressure: in_ready drops only while both banks are full; ignored stalls set sticky overrun.
module fft_input_collector
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [N*OUT_W-1:0]      frame_real,
  output logic [N*OUT_W-1:0]      frame_imag,
  output logic [7:0]              frame_cnt,
  output logic                    overrun
);

  logic [2:0] r_wptr;
  logic       r_wbank;
  logic       r_rbank;
  logic [1:0] r_full;
  logic [7:0] r_frame_cnt;
  logic       r_overrun;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_consume;
  cplx32_t         w_wdat;
  cplx32_t [N-1:0] w_b0;
  cplx32_t [N-1:0] w_b1;
  cplx32_t [N-1:0] w_rsel;

  // Both flags decode registered state only, so no input reaches an output combinationally.
  assign w_in_ready  = !r_full[r_wbank];
  assign w_accept    = in_valid && w_in_ready;
  assign w_consume   = r_full[r_rbank] && frame_ready;

  assign w_wdat.re = q88_to_q1616(in_real);
  assign w_wdat.im = q88_to_q1616(in_imag);

  fft_frame_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && !r_wbank),
    .i_waddr (r_wptr),
    .i_wdat  (w_wdat),
    .o_words (w_b0)
  );

  fft_frame_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && r_wbank),
    .i_waddr (r_wptr),
    .i_wdat  (w_wdat),
    .o_words (w_b1)
  );

  assign w_rsel = r_rbank ? w_b1 : w_b0;

  // Write pointer, bank flags and counters. Fill and drain always touch different banks
  // (a filling bank is never full, a draining one always is), so both may update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= 3'd0;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_full      <= 2'b00;
      r_frame_cnt <= 8'd0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + 3'd1;
        if (r_wptr == 3'd7) begin
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= ~r_wbank;
        end
      end
      if (w_consume) begin
        r_full[r_rbank] <= 1'b0;
        r_rbank         <= ~r_rbank;
        r_frame_cnt     <= r_frame_cnt + 8'd1;
      end
      if (in_valid && !w_in_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Flatten the selected read bank: word k sits at bits [k*32+31 : k*32].
  always_comb begin
    frame_real = '0;
    frame_imag = '0;
    for (int k = 0; k < N; k++) begin
      frame_real[k*OUT_W +: OUT_W] = w_rsel[k].re;
      frame_imag[k*OUT_W +: OUT_W] = w_rsel[k].im;
    end
  end

  assign in_ready    = w_in_ready;
  assign frame_valid = r_full[r_rbank];
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_fft_input_collector.sv
// Self-checking bench for fft_input_collector: conversion table plus frame scoreboard.
// Inputs change 1ns after the rising edge; outputs are observed on the falling edge.
// Expected frames are built from accepted samples and compared when a frame is consumed.
module tb_fft_input_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_real;
  logic [15:0]  in_imag;
  logic         frame_valid;
  logic         frame_ready;
  logic [255:0] frame_real;
  logic [255:0] frame_imag;
  logic [7:0]   frame_cnt;
  logic         overrun;

  fft_input_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_real  (frame_real),
    .frame_imag  (frame_imag),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [31:0] dexp;
  } conv_vec_t;

  typedef struct {
    logic [255:0] re;
    logic [255:0] im;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  int     cur_n;
  int     cons_cnt;
  int     n_steps;
  int     n_pass;
  int     n_total;

  function automatic logic [31:0] model(input logic [15:0] x);
    return {{8{x[15]}}, x, 8'h00};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic step(output bit acc);
    frame_t e;
    @(negedge clk);
    n_steps++;
    acc = in_valid && in_ready;
    if (acc) begin
      cur.re[cur_n*32 +: 32] = model(in_real);
      cur.im[cur_n*32 +: 32] = model(in_imag);
      cur_n++;
      if (cur_n == 8) begin
        exp_q.push_back(cur);
        cur_n = 0;
      end
    end
    if (frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_frame: consumed frame real=%h, none expected", frame_real);
      end else begin
        e = exp_q.pop_front();
        check("sb_frame_real", frame_real, e.re);
        check("sb_frame_imag", frame_imag, e.im);
        cons_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_real = re;
    in_imag = im;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: sample %h not accepted, got in_ready=%b, want accept within 50 cycles", re, in_ready);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    cur_n = 0;
    cons_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    conv_vec_t tab[8];
    logic [15:0] v;
    bit acc;
    int s0;

    n_pass = 0; n_total = 0; n_steps = 0; cur_n = 0; cons_cnt = 0;
    in_real = '0; in_imag = '0; in_valid = 1'b0; frame_ready = 1'b0;
    rst_n = 1'b0;

    tab[0] = '{16'h0100, 32'h0001_0000};
    tab[1] = '{16'hFF80, 32'hFFFF_8000};
    tab[2] = '{16'h7FFF, 32'h007F_FF00};
    tab[3] = '{16'h8000, 32'hFF80_0000};
    tab[4] = '{16'h0001, 32'h0000_0100};
    tab[5] = '{16'hFFFF, 32'hFFFF_FF00};
    tab[6] = '{16'h0000, 32'h0000_0000};
    tab[7] = '{16'h1234, 32'h0012_3400};

    // Reset values.
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_real", frame_real, 0);
    check("rst_frame_imag", frame_imag, 0);

    // Ramp 1.0 .. 8.0: frame_valid appears the cycle after the 8th accept.
    for (int i = 0; i < 7; i++) begin
      v = 16'((i + 1) * 256);
      send(v, 16'h0000);
    end
    check("fv_before_8th", frame_valid, 0);
    send(16'h0800, 16'h0000);
    check("fv_after_8th", frame_valid, 1);
    check("ramp_word0", frame_real[31:0], 32'h0001_0000);
    check("ramp_word7", frame_real[255:224], 32'h0008_0000);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    check("fv_after_consume", frame_valid, 0);
    check("cnt_after_ramp", frame_cnt, 8'(cons_cnt));

    // Conversion table: real takes entry k, imag takes entry 7-k.
    for (int i = 0; i < 8; i++) send(tab[i].din, tab[7-i].din);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("conv_re%0d", k), frame_real[k*32 +: 32], tab[k].dexp);
      check($sformatf("conv_im%0d", k), frame_imag[k*32 +: 32], tab[7-k].dexp);
    end
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;

    // Both banks full, then an ignored stall: overrun, sample dropped, frame held.
    do_reset();
    for (int i = 0; i < 16; i++) send(16'($urandom), 16'($urandom));
    check("both_full_in_ready", in_ready, 0);
    check("no_overrun_yet", overrun, 0);
    in_valid = 1'b1;
    in_real = 16'hDEAD;
    in_imag = 16'hBEEF;
    step(acc);
    in_valid = 1'b0;
    check("dropped_sample", acc, 0);
    check("overrun_set", overrun, 1);
    check("held_frame_real", frame_real, exp_q[0].re);
    check("held_frame_valid", frame_valid, 1);
    frame_ready = 1'b1;
    idle(2);
    frame_ready = 1'b0;
    check("cnt_after_drain", frame_cnt, 8'd2);
    check("drain_queue_empty", exp_q.size(), 0);

    // Full throughput for 4 frames with frame_ready held high.
    do_reset();
    frame_ready = 1'b1;
    s0 = n_steps;
    for (int i = 0; i < 32; i++) send(16'($urandom), 16'($urandom));
    check("no_stall_cycles", n_steps - s0, 32);
    idle(2);
    frame_ready = 1'b0;
    check("cnt_four_frames", frame_cnt, 8'd4);
    check("stream_queue_empty", exp_q.size(), 0);

    // Completion of B1 and consumption of B0 on the same edge.
    do_reset();
    for (int i = 0; i < 15; i++) send(16'($urandom), 16'($urandom));
    check("b0_full_fv", frame_valid, 1);
    check("b1_filling_rdy", in_ready, 1);
    frame_ready = 1'b1;
    send(16'($urandom), 16'($urandom));
    frame_ready = 1'b0;
    check("no_gap_fv", frame_valid, 1);
    check("b0_freed_rdy", in_ready, 1);
    check("cnt_after_overlap", frame_cnt, 8'd1);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    check("fv_after_second", frame_valid, 0);
    check("cnt_after_second", frame_cnt, 8'd2);

    // Reset mid-frame: partial data discarded, count restarts.
    for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));
    do_reset();
    check("midrst_cnt", frame_cnt, 0);
    check("midrst_fv", frame_valid, 0);
    for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom));
    check("midrst_new_fv", frame_valid, 1);
    frame_ready = 1'b1;
    idle(1);
    frame_ready = 1'b0;
    check("midrst_cnt_after", frame_cnt, 8'd1);
    check("midrst_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
